// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: packs SHIFT_AMOUNT-bit chunks into SIZE-bit words,
// with a one-word holding slot in the accumulator so input can stall cleanly behind the output.
module shift_deser #(
  parameter int SIZE         = 16,
  parameter int SHIFT_AMOUNT = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [SHIFT_AMOUNT-1:0] din_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [SIZE-1:0]         dout_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    busy_o
);

  localparam int N  = SIZE / SHIFT_AMOUNT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [SIZE-1:0] acc;
  logic [SIZE-1:0] acc_next;
  logic [CW-1:0]   count;
  logic            acc_full;
  logic            accept;
  logic            last;
  logic            slot_free;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on valid, and a producer holds its data until it is taken.
  assign in_ready_o = !acc_full;
  assign accept     = in_valid_i && !acc_full;
  assign last       = accept && (count == CW'(N - 1));
  assign slot_free  = !out_valid_o || out_ready_i;
  assign busy_o     = (count != '0) || acc_full;

  generate
    if (N == 1) begin : g_single
      assign acc_next = din_i;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign acc_next = {acc[SIZE-SHIFT_AMOUNT-1:0], din_i};
    end else begin : g_lsb
      assign acc_next = {din_i, acc[SIZE-1:SHIFT_AMOUNT]};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      acc         <= '0;
      count       <= '0;
      acc_full    <= 1'b0;
      dout_o      <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (accept) begin
        acc   <= acc_next;
        count <= last ? '0 : count + CW'(1);
      end
      // accept is blocked while acc_full, so a parked word and a new Nth chunk never coincide
      if (acc_full && slot_free) begin
        dout_o      <= acc;
        out_valid_o <= 1'b1;
        acc_full    <= 1'b0;
      end else if (last && slot_free) begin
        dout_o      <= acc_next;
        out_valid_o <= 1'b1;
      end else if (last) begin
        acc_full <= 1'b1;
      end else if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
